// File: rtl/ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// ball_motion_ctrl
//
// Per-frame motion sequencer for the bouncing-ball display pipeline. On the
// first line of vertical blanking (HCOORD==0, VCOORD==V_ACTIVE) it steps the
// ball one frame: CALC_X and CALC_Y compute the new position and direction
// (with wall reflection) into shadow registers, and COMMIT copies them to the
// outputs in a single edge, so XPos/YPos never move during the active picture.
// Speed-load requests from game control are honoured only at COMMIT.
//
// Ports
//   CLK               system/pixel clock, rising edge
//   RST               synchronous active-high reset
//   EN                motion enable; a low EN suppresses the frame trigger
//   HCOORD, VCOORD    scan counters from the VGA timing generator
//   CFG_REQ           speed-load request, held until CFG_ACK
//   CFG_XSPD/YSPD     requested speed magnitudes
//   XPos, YPos        committed ball top-left coordinate
//   XSpeed, YSpeed    committed speed magnitudes
//   XDir, YDir        1 = right/down, 0 = left/up
//   BUSY              high while an update is in progress
//   FRAME_TICK        one-cycle pulse on the cycle after commit
//   CFG_ACK           one-cycle pulse when new speeds were loaded
//   BOUNCES           saturating wall-reflection count
// ---------------------------------------------------------------------------
module ball_motion_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BALL_SIZE  = 16,
  parameter int X_INIT     = 312,
  parameter int Y_INIT     = 232,
  parameter int SPEED_INIT = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [9:0] HCOORD,
  input  logic [9:0] VCOORD,
  input  logic       CFG_REQ,
  input  logic [5:0] CFG_XSPD,
  input  logic [5:0] CFG_YSPD,
  output logic [9:0] XPos,
  output logic [9:0] YPos,
  output logic [5:0] XSpeed,
  output logic [5:0] YSpeed,
  output logic       XDir,
  output logic       YDir,
  output logic       BUSY,
  output logic       FRAME_TICK,
  output logic       CFG_ACK,
  output logic [7:0] BOUNCES
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CALC_X = 2'd1;
  localparam logic [1:0] CALC_Y = 2'd2;
  localparam logic [1:0] COMMIT = 2'd3;

  localparam logic [9:0] X_MAX  = 10'(H_ACTIVE - BALL_SIZE);
  localparam logic [9:0] Y_MAX  = 10'(V_ACTIVE - BALL_SIZE);
  localparam logic [9:0] V_LINE = 10'(V_ACTIVE);

  // Result of stepping one axis by one frame.
  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       bounce;
  } axis_step_t;

  // One-axis move with reflection. The sum is formed in 11 bits so a ball
  // near the far wall cannot wrap past 1023 and miss the comparison. A zero
  // speed never reflects, even when the ball already touches a wall.
  function automatic axis_step_t axis_step(input logic [9:0] pos,
                                           input logic [5:0] spd,
                                           input logic       dir,
                                           input logic [9:0] lim);
    logic [10:0] sum;
    axis_step_t  r;
    sum      = {1'b0, pos} + {5'b0, spd};
    r.pos    = pos;
    r.dir    = dir;
    r.bounce = 1'b0;
    if (spd != 6'd0) begin
      if (dir) begin
        if (sum >= {1'b0, lim}) r = '{pos: lim, dir: 1'b0, bounce: 1'b1};
        else                    r.pos = sum[9:0];
      end else begin
        if (pos <= {4'b0, spd}) r = '{pos: 10'd0, dir: 1'b1, bounce: 1'b1};
        else                    r.pos = pos - {4'b0, spd};
      end
    end
    return r;
  endfunction

  logic [1:0] state;
  axis_step_t x_step;   // shadow result of CALC_X
  axis_step_t y_step;   // shadow result of CALC_Y
  logic [8:0] bounce_sum;
  logic [7:0] bounces_next;

  // A corner hit adds two in one frame; the ninth bit catches overflow.
  always_comb begin
    bounce_sum   = {1'b0, BOUNCES} + {8'b0, x_step.bounce} + {8'b0, y_step.bounce};
    bounces_next = bounce_sum[8] ? 8'hFF : bounce_sum[7:0];
  end

  assign BUSY = (state != IDLE);

  // NOTE: state registers use non-blocking assignments so every register in
  // this block samples the pre-edge values; blocking here would let CALC_X
  // results leak into the same edge's COMMIT logic in simulation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      x_step     <= '0;
      y_step     <= '0;
      XPos       <= 10'(X_INIT);
      YPos       <= 10'(Y_INIT);
      XSpeed     <= 6'(SPEED_INIT);
      YSpeed     <= 6'(SPEED_INIT);
      XDir       <= 1'b1;
      YDir       <= 1'b1;
      FRAME_TICK <= 1'b0;
      CFG_ACK    <= 1'b0;
      BOUNCES    <= 8'd0;
    end else begin
      FRAME_TICK <= 1'b0;
      CFG_ACK    <= 1'b0;
      case (state)
        IDLE: begin
          if (EN && (HCOORD == 10'd0) && (VCOORD == V_LINE)) state <= CALC_X;
        end
        CALC_X: begin
          x_step <= axis_step(XPos, XSpeed, XDir, X_MAX);
          state  <= CALC_Y;
        end
        CALC_Y: begin
          y_step <= axis_step(YPos, YSpeed, YDir, Y_MAX);
          state  <= COMMIT;
        end
        COMMIT: begin
          XPos       <= x_step.pos;
          YPos       <= y_step.pos;
          XDir       <= x_step.dir;
          YDir       <= y_step.dir;
          BOUNCES    <= bounces_next;
          FRAME_TICK <= 1'b1;
          // New speeds take effect on the next frame's calculation only.
          if (CFG_REQ) begin
            XSpeed  <= CFG_XSPD;
            YSpeed  <= CFG_YSPD;
            CFG_ACK <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ball_motion_ctrl
//
// Drives ball_motion_ctrl with directed frame triggers (the scan counters are
// placed directly on the trigger coordinate instead of free-running a whole
// 801x526 raster) followed by randomized frames. A frame-level reference
// model in plain integer arithmetic supplies every expected value; a few
// milestones are also compared against hand-computed positions.
// ---------------------------------------------------------------------------
module tb_ball_motion_ctrl;

  localparam int V_ACTIVE = 480;
  localparam int X_MAX    = 624;
  localparam int Y_MAX    = 464;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [9:0] HCOORD;
  logic [9:0] VCOORD;
  logic       CFG_REQ;
  logic [5:0] CFG_XSPD;
  logic [5:0] CFG_YSPD;
  logic [9:0] XPos;
  logic [9:0] YPos;
  logic [5:0] XSpeed;
  logic [5:0] YSpeed;
  logic       XDir;
  logic       YDir;
  logic       BUSY;
  logic       FRAME_TICK;
  logic       CFG_ACK;
  logic [7:0] BOUNCES;

  ball_motion_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .EN         (EN),
    .HCOORD     (HCOORD),
    .VCOORD     (VCOORD),
    .CFG_REQ    (CFG_REQ),
    .CFG_XSPD   (CFG_XSPD),
    .CFG_YSPD   (CFG_YSPD),
    .XPos       (XPos),
    .YPos       (YPos),
    .XSpeed     (XSpeed),
    .YSpeed     (YSpeed),
    .XDir       (XDir),
    .YDir       (YDir),
    .BUSY       (BUSY),
    .FRAME_TICK (FRAME_TICK),
    .CFG_ACK    (CFG_ACK),
    .BOUNCES    (BOUNCES)
  );

  always #5 CLK = ~CLK;

  int compared   = 0;
  int mismatched = 0;

  // Reference model state: the ball as seen at frame granularity.
  int m_x, m_y, m_sx, m_sy, m_dx, m_dy, m_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 312; m_y = 232; m_sx = 2; m_sy = 2; m_dx = 1; m_dy = 1; m_b = 0;
  endtask

  // Signed displacement, then clamp to [0, lim]; touching a wall flips.
  task automatic model_axis(inout int pos, inout int dir, input int spd, input int lim);
    int p;
    if (spd == 0) return;
    p = pos + ((dir != 0) ? spd : -spd);
    if (p >= lim) begin
      pos = lim; dir = 0; m_b = (m_b + 1 > 255) ? 255 : m_b + 1;
    end else if (p <= 0) begin
      pos = 0; dir = 1; m_b = (m_b + 1 > 255) ? 255 : m_b + 1;
    end else begin
      pos = p;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".xpos"},    XPos,    m_x);
    check({tag, ".ypos"},    YPos,    m_y);
    check({tag, ".xspd"},    XSpeed,  m_sx);
    check({tag, ".yspd"},    YSpeed,  m_sy);
    check({tag, ".xdir"},    XDir,    m_dx);
    check({tag, ".ydir"},    YDir,    m_dy);
    check({tag, ".bounces"}, BOUNCES, m_b);
  endtask

  // One frame: trigger coordinate presented at edge k and held through k+2
  // (the extra samples must be ignored while busy). Optionally RST at k+2.
  task automatic frame(input bit en, input bit req, input int xs, input int ys, input bit rst_mid);
    bit ack_exp;
    @(negedge CLK);
    EN = en; CFG_REQ = req; CFG_XSPD = 6'(xs); CFG_YSPD = 6'(ys);
    HCOORD = 10'd0; VCOORD = 10'(V_ACTIVE);
    @(posedge CLK); #1;                       // edge k
    check("busy_k", BUSY, en);
    check("tick_k", FRAME_TICK, 0);
    @(posedge CLK); #1;                       // edge k+1
    check("busy_k1", BUSY, en);
    check("tick_k1", FRAME_TICK, 0);
    if (rst_mid) begin
      @(negedge CLK);
      RST = 1'b1; HCOORD = 10'd1;
      @(posedge CLK); #1;                     // edge k+2 with reset
      model_reset();
      check_state("rst_mid");
      check("rst_mid.busy", BUSY, 0);
      check("rst_mid.tick", FRAME_TICK, 0);
      check("rst_mid.ack",  CFG_ACK, 0);
      @(negedge CLK);
      RST = 1'b0; CFG_REQ = 1'b0;
      return;
    end
    @(posedge CLK); #1;                       // edge k+2
    check("tick_k2", FRAME_TICK, 0);
    @(negedge CLK);
    HCOORD = 10'd1;
    @(posedge CLK); #1;                       // edge k+3: commit
    ack_exp = en && CFG_REQ;
    if (en) begin
      model_axis(m_x, m_dx, m_sx, X_MAX);
      model_axis(m_y, m_dy, m_sy, Y_MAX);
      if (ack_exp) begin m_sx = xs; m_sy = ys; end
    end
    check("tick_k3", FRAME_TICK, en);
    check("ack_k3",  CFG_ACK, ack_exp);
    check("busy_k3", BUSY, 0);
    check_state("frame");
    @(negedge CLK);
    if (ack_exp) CFG_REQ = 1'b0;
    @(posedge CLK); #1;                       // edge k+4
    check("tick_k4", FRAME_TICK, 0);
    check("ack_k4",  CFG_ACK, 0);
    check("busy_k4", BUSY, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    RST = 1'b1; EN = 1'b0; CFG_REQ = 1'b0; CFG_XSPD = '0; CFG_YSPD = '0;
    HCOORD = 10'd0; VCOORD = 10'd0;
    repeat (2) @(posedge CLK);
    #1;
    model_reset();
    check_state("reset");
    check("reset.busy", BUSY, 0);
    check("reset.tick", FRAME_TICK, 0);
    check("reset.ack",  CFG_ACK, 0);
    @(negedge CLK);
    RST = 1'b0;

    // First frame moves at the reset speeds; x speed 44 / y speed 0 loaded.
    frame(1, 1, 44, 0, 0);
    check("first.x", XPos, 314);
    check("first.y", YPos, 234);
    repeat (6) frame(1, 0, 0, 0, 0);
    frame(1, 1, 0, 57, 0);
    check("steer.x", XPos, 622);
    repeat (3) frame(1, 0, 0, 0, 0);
    frame(1, 1, 5, 5, 0);
    check("pre_corner.y", YPos, 462);
    check("pre_corner.dx", XDir, 1);

    // Corner hit: both walls in one frame.
    frame(1, 1, 27, 0, 0);
    check("corner.x", XPos, 624);
    check("corner.y", YPos, 464);
    check("corner.dx", XDir, 0);
    check("corner.dy", YDir, 0);
    check("corner.b", BOUNCES, 2);

    // EN low: no tick, no ack, nothing moves; the request stays pending.
    frame(0, 1, 27, 0, 0);
    check("en0.x", XPos, 624);
    frame(1, 1, 27, 0, 0);
    repeat (21) frame(1, 0, 0, 0, 0);
    frame(1, 1, 3, 0, 0);
    check("left_pre.x", XPos, 3);
    frame(1, 1, 0, 0, 0);
    check("left_exact.x", XPos, 0);
    check("left_exact.dx", XDir, 1);
    check("left_exact.b", BOUNCES, 3);
    // Speed zero at the wall: no move and no bounce, on either axis.
    frame(1, 0, 0, 0, 0);
    check("spd0.x", XPos, 0);
    check("spd0.y", YPos, 464);
    check("spd0.b", BOUNCES, 3);

    frame(1, 1, 62, 0, 0);
    repeat (9) frame(1, 0, 0, 0, 0);
    frame(1, 1, 4, 0, 0);
    check("right_pre.x", XPos, 620);
    frame(1, 0, 0, 0, 0);
    check("right.x", XPos, 624);
    check("right.dx", XDir, 0);
    check("right.b", BOUNCES, 4);
    frame(1, 0, 0, 0, 0);
    check("right_next.x", XPos, 620);

    // Config 10/1: old speeds this frame, new speeds next frame.
    frame(1, 1, 10, 1, 0);
    check("cfg_old.x", XPos, 616);
    check("cfg_old.y", YPos, 464);
    frame(1, 0, 0, 0, 0);
    check("cfg_new.x", XPos, 606);
    check("cfg_new.y", YPos, 463);

    // Reset in the middle of an update, then a normal frame from reset.
    frame(1, 0, 0, 0, 1);
    frame(1, 0, 0, 0, 0);
    check("post_rst.x", XPos, 314);
    check("post_rst.y", YPos, 234);

    // Randomized frames against the model.
    for (int i = 0; i < 60; i++) begin
      bit en_r, req_r;
      int xs_r, ys_r;
      en_r  = ($urandom_range(0, 7) != 0);
      req_r = ($urandom_range(0, 2) == 0);
      xs_r  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      ys_r  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63));
      frame(en_r, req_r, xs_r, ys_r, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ball_motion_ctrl.md
# ball_motion_ctrl

Per-frame motion sequencer for the bouncing-ball display pipeline. It watches the `HCOORD`/`VCOORD` scan counters from the VGA timing generator. On the first line of vertical blanking it runs a short multi-cycle update of ball position, speed and direction, including wall reflection, and commits the results atomically so `XPos`/`YPos` never change during the active picture. It also gives game-control logic a request/acknowledge port for loading new speeds, applied only at frame commit.

## Interface
- `H_ACTIVE`, 640: visible pixels per line; x range is 0..H_ACTIVE-BALL_SIZE.
- `V_ACTIVE`, 480: visible lines; also the VCOORD value that triggers the update.
- `BALL_SIZE`, 16: ball edge length in pixels.
- `X_INIT`, 312: reset x position.
- `Y_INIT`, 232: reset y position.
- `SPEED_INIT`, 2: reset value of XSpeed and YSpeed.
- `CLK`  in  1  system/pixel clock; all logic on rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `EN`  in  1  motion enable; when low, triggers are ignored.
- `HCOORD`  in  10  horizontal scan count, 0..800.
- `VCOORD`  in  10  vertical scan count, 0..525.
- `CFG_REQ`  in  1  speed-load request; held high until `CFG_ACK`.
- `CFG_XSPD`, `CFG_YSPD`  in  6 each  requested speed magnitudes.
- `XPos`, `YPos`  out  10 each  committed ball top-left coordinate.
- `XSpeed`, `YSpeed`  out  6 each  committed speed magnitudes.
- `XDir`, `YDir`  out  1 each  1 = +x (right) / +y (down), 0 = negative.
- `BUSY`  out  1  high while in any non-IDLE state.
- `FRAME_TICK`  out  1  one-cycle pulse on the cycle after commit.
- `CFG_ACK`  out  1  one-cycle pulse; the speeds were loaded.
- `BOUNCES`  out  8  saturating count of wall reflections (at 255 it holds).

## Operation
- The trigger condition is `EN` && `HCOORD`==0 && `VCOORD`==V_ACTIVE && state==IDLE. It fires at most once per frame. A trigger in any other state is ignored.
- FSM states and transitions:
  - IDLE → CALC_X on trigger.
  - CALC_X → CALC_Y → COMMIT → IDLE, unconditionally.
- CALC_X, using shadow registers `nx` and `ndx` with max = H_ACTIVE-BALL_SIZE:
  - XDir=1 and XPos+XSpeed >= max: nx = max, ndx = 0, reflection.
  - XDir=0 and XPos <= XSpeed: nx = 0, ndx = 1, reflection.
  - Otherwise: nx = XPos ± XSpeed, ndx = XDir.
  - Use 11-bit arithmetic for the compare so nothing wraps.
- CALC_Y: same rules with YPos, YSpeed, YDir and max = V_ACTIVE-BALL_SIZE.
- Speed 0: the position is unchanged and there is no reflection, even when the ball sits at a wall.
- A landing exactly on a wall counts as a reflection, so the direction flips that same frame.
- A corner hit flips both directions in one frame. BOUNCES increments by 2 (saturating).
- COMMIT:
  - Copy `nx`/`ny`/`ndx`/`ndy` into XPos/YPos/XDir/YDir.
  - If CFG_REQ is high, load XSpeed=CFG_XSPD and YSpeed=CFG_YSPD and pulse CFG_ACK.
  - New speeds first affect the next frame's calculation.
- CFG_REQ raised while the FSM is busy or in IDLE is served at the next COMMIT. Directions are never changed by a config load.
- EN falling mid-update does not abort; the sequence completes.
- RST mid-update discards the shadow values; nothing is committed.
- Reset values: XPos=X_INIT, YPos=Y_INIT, XSpeed=YSpeed=SPEED_INIT, XDir=YDir=1, BUSY=0, FRAME_TICK=0, CFG_ACK=0, BOUNCES=0, state=IDLE.

## Timing
- Trigger sampled at edge k:
  - BUSY is high after edge k.
  - CALC_X runs at edge k+1 and CALC_Y at edge k+2.
  - Outputs update at edge k+3; FRAME_TICK and CFG_ACK are high for the cycle after edge k+3.
  - BUSY is low after edge k+3.
- All outputs are registered; there are no combinational paths from input to output.
- With RST asserted at edge j, all outputs hold reset values after edge j. A trigger in the same cycle as RST is lost.
- The update completes within 4 clocks of the start of line V_ACTIVE, well inside vertical blanking.

## Test plan
- Reset, EN=1, free-running 801×526 counters: after the first trigger, XPos=314, YPos=234, FRAME_TICK pulses exactly once per frame, 3 cycles after the trigger.
- Right wall: XPos=620, XSpeed=4, XDir=1 → after one frame XPos=624, XDir=0, BOUNCES+1; next frame XPos=620.
- Left wall exact landing: XPos=3, XSpeed=3, XDir=0 → XPos=0, XDir=1. With speed 0 at XPos=0: no change and no bounce.
- Corner: XPos=622, YPos=462, speeds 5/5, directions 1/1 → XPos=624, YPos=464, both directions 0, BOUNCES+2.
- Config: raise CFG_REQ with XSPD=10, YSPD=1 mid-frame → CFG_ACK pulses at the next COMMIT. That frame moves at the old speeds and the following frame moves by 10/1. With EN=0, no ACK, no FRAME_TICK and no position change occur.
- Reset mid-update: assert RST at edge k+2 → no commit, outputs equal reset values, and the next frame updates normally.
